// File: rtl/reg_native_resp_pkg.sv
// Shared types and width helpers for the reg_native_if responder.
// Build option: REG_NATIVE_RESP_TIMEOUT_EN enables the mem_ack timeout.
package reg_native_resp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned BYTE_BITS = 8;

    function automatic int unsigned word_bytes(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    // Number of low byte-address bits that must be zero for a word-aligned offset.
    function automatic int unsigned align_bits(input int unsigned data_width);
        return $clog2(word_bytes(data_width));
    endfunction

endpackage

// File: rtl/reg_native_resp_decode.sv
// Combinational decode of a reg_native_if request: range, alignment and
// command checks, plus the memory word address.
module reg_native_resp_decode
    import reg_native_resp_pkg::*;
#(
    parameter int                        BUS_DATA_WIDTH = 32,
    parameter int                        BUS_ADDR_WIDTH = 64,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        DEPTH          = 256,
    parameter int                        MEM_ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic                      dec_err,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr
);

    localparam int unsigned WB    = word_bytes(BUS_DATA_WIDTH);
    localparam int unsigned ALIGN = align_bits(BUS_DATA_WIDTH);
    localparam logic [BUS_ADDR_WIDTH-1:0] SPAN       = BUS_ADDR_WIDTH'(DEPTH * WB);
    localparam logic [BUS_ADDR_WIDTH-1:0] ALIGN_MASK = BUS_ADDR_WIDTH'(WB - 1);

    logic                      below;
    logic [BUS_ADDR_WIDTH-1:0] off;

    // The borrow out of the subtraction flags an address below the window.
    assign {below, off} = {1'b0, addr} - {1'b0, BASE_ADDR};

    assign mem_addr = MEM_ADDR_WIDTH'(off >> ALIGN);

    assign dec_err = below
                   | (off >= SPAN)
                   | ((off & ALIGN_MASK) != '0)
                   | (wr_en == rd_en);

endmodule

// File: rtl/reg_native_if_responder.sv
// Responder end of reg_native_if: executes single-outstanding requests on a
// word-addressed memory port. Build option: REG_NATIVE_RESP_TIMEOUT_EN.
module reg_native_if_responder
    import reg_native_resp_pkg::*;
#(
    parameter int                        BUS_DATA_WIDTH = 32,
    parameter int                        BUS_ADDR_WIDTH = 64,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        DEPTH          = 256,
    parameter int                        MEM_ADDR_WIDTH = $clog2(DEPTH),
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                      native_clk,
    input  logic                      native_rst,
    input  logic                      req_vld,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [BUS_DATA_WIDTH-1:0] wr_data,
    output logic                      ack_vld,
    output logic                      err,
    output logic [BUS_DATA_WIDTH-1:0] rd_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_DATA_WIDTH-1:0] mem_wdata,
    input  logic                      mem_ack,
    input  logic [BUS_DATA_WIDTH-1:0] mem_rdata,
    output logic                      drop_err
);

`ifdef REG_NATIVE_RESP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                    state, state_n;
    logic                      dec_err;
    logic [MEM_ADDR_WIDTH-1:0] dec_addr;
    logic                      mem_req_n, mem_we_n, ack_vld_n, err_n, drop_err_n;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_n;
    logic [BUS_DATA_WIDTH-1:0] mem_wdata_n, rd_data_n;
    logic [CNT_W-1:0]          tmo_cnt, tmo_cnt_n;

    reg_native_resp_decode #(
        .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
        .BUS_ADDR_WIDTH(BUS_ADDR_WIDTH),
        .BASE_ADDR     (BASE_ADDR),
        .DEPTH         (DEPTH),
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_decode (
        .addr    (addr),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .dec_err (dec_err),
        .mem_addr(dec_addr)
    );

    always_ff @(posedge native_clk) begin
        if (native_rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack_vld   <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            drop_err  <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            ack_vld   <= ack_vld_n;
            err       <= err_n;
            rd_data   <= rd_data_n;
            drop_err  <= drop_err_n;
            tmo_cnt   <= TMO_EN ? tmo_cnt_n : '0;
        end
    end

    // Memory-side fields hold between accesses; responses are one-cycle pulses.
    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        ack_vld_n   = 1'b0;
        err_n       = 1'b0;
        rd_data_n   = '0;
        drop_err_n  = drop_err;
        tmo_cnt_n   = tmo_cnt;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    if (dec_err) begin
                        ack_vld_n = 1'b1;
                        err_n     = 1'b1;
                    end else begin
                        mem_req_n   = 1'b1;
                        mem_we_n    = wr_en;
                        mem_addr_n  = dec_addr;
                        mem_wdata_n = wr_data;
                        tmo_cnt_n   = CNT_W'(1);
                        state_n     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (req_vld) begin
                    drop_err_n = 1'b1;
                end
                // mem_ack in the expiry cycle still completes successfully.
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    ack_vld_n = 1'b1;
                    rd_data_n = mem_we ? '0 : mem_rdata;
                    tmo_cnt_n = '0;
                    state_n   = IDLE;
                end else if (TMO_EN && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
                    mem_req_n = 1'b0;
                    ack_vld_n = 1'b1;
                    err_n     = 1'b1;
                    tmo_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_native_if_responder.sv
// Self-checking bench for reg_native_if_responder; the bench acts as the memory
// and predicts responses from an address-window model and a word array.
module tb_reg_native_if_responder;

    localparam int          DW   = 32;
    localparam int          AW   = 64;
    localparam logic [63:0] BASE = 64'h1000;
    localparam int          DEP  = 256;
    localparam int          MAW  = 8;
    localparam int          TMO  = 4;

    logic          native_clk = 1'b0;
    logic          native_rst = 1'b1;
    logic          req_vld = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ack_vld, err, mem_req, mem_we, drop_err;
    logic [DW-1:0] rd_data, mem_wdata;
    logic [MAW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_model [DEP];
    logic [DW-1:0] exp_q [$];

    reg_native_if_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_ADDR_WIDTH(AW),
        .BASE_ADDR     (BASE),
        .DEPTH         (DEP),
        .MEM_ADDR_WIDTH(MAW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .native_clk(native_clk),
        .native_rst(native_rst),
        .req_vld   (req_vld),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
        .ack_vld   (ack_vld),
        .err       (err),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .drop_err  (drop_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 native_clk = ~native_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [63:0] a, input bit w, input bit r);
        if (w == r) return 1'b1;
        if (a < BASE) return 1'b1;
        if (a - BASE >= 64'(DEP * 4)) return 1'b1;
        if ((a - BASE) % 4 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_idx(input logic [63:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_access(input logic [63:0] a, input bit w, input bit r,
                             input logic [DW-1:0] wd, input int delay, input string tag);
        bit e;
        int idx;
        logic [DW-1:0] exp_rd;
        logic [MAW-1:0] exp_addr;
        e = model_err(a, w, r);
        idx = e ? 0 : model_idx(a);
        exp_addr = idx[MAW-1:0];
        @(negedge native_clk);
        req_vld = 1'b1; addr = a; wr_en = w; rd_en = r; wr_data = wd;
        @(negedge native_clk);
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        if (e) begin
            checks++;
            if (ack_vld !== 1'b1 || err !== 1'b1 || rd_data !== '0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s dec_err resp: ack=%b err=%b rd=%h mem_req=%b, exp ack=1 err=1 rd=0 mem_req=0",
                         tag, ack_vld, err, rd_data, mem_req);
            end
            return;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_we !== w || mem_addr !== exp_addr ||
            (w && mem_wdata !== wd) || ack_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s mem issue: req=%b we=%b addr=%0d wdata=%h ack=%b, exp req=1 we=%b addr=%0d wdata=%h ack=0",
                     tag, mem_req, mem_we, mem_addr, mem_wdata, ack_vld, w, exp_addr, wd);
        end
        exp_q.push_back(w ? '0 : mem_model[idx]);
        for (int i = 0; i < delay; i++) begin
            @(negedge native_clk);
            checks++;
            if (mem_req !== 1'b1 || ack_vld !== 1'b0 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s hold: req=%b ack=%b addr=%0d, exp req=1 ack=0 addr=%0d",
                         tag, mem_req, ack_vld, mem_addr, exp_addr);
            end
        end
        mem_ack = 1'b1;
        mem_rdata = w ? DW'($urandom) : mem_model[idx];
        @(negedge native_clk);
        mem_ack = 1'b0;
        mem_rdata = DW'($urandom);
        exp_rd = exp_q.pop_front();
        checks++;
        if (ack_vld !== 1'b1 || err !== 1'b0 || rd_data !== exp_rd || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s resp: ack=%b err=%b rd=%h mem_req=%b, exp ack=1 err=0 rd=%h mem_req=0",
                     tag, ack_vld, err, rd_data, mem_req, exp_rd);
        end
        if (w) mem_model[idx] = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        native_rst = 1'b1;
        repeat (3) @(negedge native_clk);
        checks++;
        if ({ack_vld, err, rd_data, mem_req, mem_we, mem_addr, mem_wdata, drop_err} !== '0) begin
            errors++;
            $display("FAIL reset: ack=%b err=%b rd=%h req=%b we=%b addr=%0d wdata=%h drop=%b, exp all 0",
                     ack_vld, err, rd_data, mem_req, mem_we, mem_addr, mem_wdata, drop_err);
        end
        native_rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_access(64'h1008, 1'b1, 1'b0, 32'hDEADBEEF, 1, "wr_1008");
        do_access(64'h1008, 1'b0, 1'b1, 32'h0, 1, "rd_1008");
    endtask

    task automatic test_decode_errors();
        do_access(64'h1003, 1'b1, 1'b0, 32'h1, 0, "misaligned");
        do_access(64'h1400, 1'b0, 1'b1, 32'h2, 0, "out_of_range");
        do_access(64'h0FFC, 1'b0, 1'b1, 32'h3, 0, "below_base");
        do_access(64'h1010, 1'b1, 1'b1, 32'h4, 0, "both_cmds");
        do_access(64'h1010, 1'b0, 1'b0, 32'h5, 0, "no_cmd");
        repeat (2) begin
            @(negedge native_clk);
            checks++;
            if (mem_req !== 1'b0 || ack_vld !== 1'b0) begin
                errors++;
                $display("FAIL dec_quiet: mem_req=%b ack=%b, exp 0 0", mem_req, ack_vld);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        bit w;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 64'($urandom_range(1, 16));
                1:       a = BASE + 64'($urandom_range(0, 1100));
                2:       a = {32'hFFFF_FFFF, 32'($urandom)};
                default: a = BASE + 64'(4 * $urandom_range(0, DEP - 1));
            endcase
            w = 1'($urandom);
            if ($urandom_range(0, 15) == 0) do_access(a, w, w, DW'($urandom), 0, "rand_cmd");
            else do_access(a, w, !w, DW'($urandom), $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd;
        wd = DW'($urandom);
        @(negedge native_clk);
        req_vld = 1'b1; addr = 64'h1020; wr_en = 1'b1; rd_en = 1'b0; wr_data = wd;
        @(negedge native_clk);
        req_vld = 1'b0; wr_en = 1'b0;
        mem_ack = 1'b1;
        @(negedge native_clk);
        mem_ack = 1'b0;
        checks++;
        if (ack_vld !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b first ack: ack=%b err=%b, exp 1 0", ack_vld, err);
        end
        mem_model[8] = wd;
        req_vld = 1'b1; addr = 64'h1020; rd_en = 1'b1;
        @(negedge native_clk);
        req_vld = 1'b0; rd_en = 1'b0;
        checks++;
        if (ack_vld !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd8) begin
            errors++;
            $display("FAIL b2b reissue: ack=%b req=%b we=%b addr=%0d, exp 0 1 0 8",
                     ack_vld, mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = wd;
        @(negedge native_clk);
        mem_ack = 1'b0;
        checks++;
        if (ack_vld !== 1'b1 || err !== 1'b0 || rd_data !== wd) begin
            errors++;
            $display("FAIL b2b second ack: ack=%b err=%b rd=%h, exp 1 0 %h", ack_vld, err, rd_data, wd);
        end
    endtask

    task automatic test_busy_drop();
        int acks;
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_pre: drop_err=%b, exp 0", drop_err);
        end
        @(negedge native_clk);
        req_vld = 1'b1; addr = 64'h1010; wr_en = 1'b1; wr_data = 32'h1234_5678;
        @(negedge native_clk);
        req_vld = 1'b1; addr = 64'h1040; wr_data = 32'hBAD0_BAD0;
        @(negedge native_clk);
        req_vld = 1'b0; wr_en = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack_vld === 1'b1) acks++;
            @(negedge native_clk);
        end
        checks++;
        if (drop_err !== 1'b1 || mem_addr !== 8'd4 || mem_wdata !== 32'h1234_5678 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy: drop=%b addr=%0d wdata=%h req=%b, exp 1 4 12345678 1",
                     drop_err, mem_addr, mem_wdata, mem_req);
        end
        mem_ack = 1'b1;
        @(negedge native_clk);
        mem_ack = 1'b0;
        mem_model[4] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            if (ack_vld === 1'b1) acks++;
            @(negedge native_clk);
        end
        checks++;
        if (acks != 1 || drop_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_acks: acks=%0d drop=%b req=%b, exp 1 1 0", acks, drop_err, mem_req);
        end
    endtask

    task automatic test_timeout();
        int hi;
`ifdef REG_NATIVE_RESP_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge native_clk);
            req_vld = 1'b1; addr = 64'h1010; rd_en = 1'b1;
            @(negedge native_clk);
            req_vld = 1'b0; rd_en = 1'b0;
            hi = 0;
            for (int i = 0; i < 20; i++) begin
                if (mem_req !== 1'b1) break;
                hi++;
                if (pass == 1 && hi == TMO) begin
                    mem_ack = 1'b1; mem_rdata = mem_model[4];
                end
                @(negedge native_clk);
                mem_ack = 1'b0;
            end
            checks++;
            if (hi != TMO || ack_vld !== 1'b1 || err !== (pass == 0) ||
                rd_data !== ((pass == 0) ? 32'h0 : mem_model[4])) begin
                errors++;
                $display("FAIL timeout pass%0d: req_cycles=%0d ack=%b err=%b rd=%h, exp %0d 1 %b",
                         pass, hi, ack_vld, err, rd_data, TMO, pass == 0);
            end
            if (pass == 0) begin
                mem_ack = 1'b1;
                repeat (2) @(negedge native_clk);
                mem_ack = 1'b0;
                checks++;
                if (ack_vld !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL late_ack: ack=%b req=%b, exp 0 0", ack_vld, mem_req);
                end
            end
        end
`else
        @(negedge native_clk);
        req_vld = 1'b1; addr = 64'h1010; rd_en = 1'b1;
        @(negedge native_clk);
        req_vld = 1'b0; rd_en = 1'b0;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req === 1'b1 && ack_vld === 1'b0) hi++;
            @(negedge native_clk);
        end
        mem_ack = 1'b1; mem_rdata = mem_model[4];
        @(negedge native_clk);
        mem_ack = 1'b0;
        checks++;
        if (hi != 30 || ack_vld !== 1'b1 || err !== 1'b0 || rd_data !== mem_model[4]) begin
            errors++;
            $display("FAIL long_wait: wait_cycles=%0d ack=%b err=%b rd=%h, exp 30 1 0 %h",
                     hi, ack_vld, err, rd_data, mem_model[4]);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        int acks;
        @(negedge native_clk);
        req_vld = 1'b1; addr = 64'h1030; wr_en = 1'b1; wr_data = 32'hCAFE_F00D;
        @(negedge native_clk);
        req_vld = 1'b0; wr_en = 1'b0;
        native_rst = 1'b1;
        @(negedge native_clk);
        native_rst = 1'b0;
        checks++;
        if ({ack_vld, err, rd_data, mem_req, mem_we, mem_addr, mem_wdata, drop_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset: ack=%b req=%b we=%b addr=%0d drop=%b, exp all 0",
                     ack_vld, mem_req, mem_we, mem_addr, drop_err);
        end
        mem_ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge native_clk);
            mem_ack = 1'b0;
            if (ack_vld === 1'b1 || mem_req === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: spurious=%0d, exp 0", acks);
        end
        do_access(64'h1030, 1'b1, 1'b0, 32'h0BAD_CAFE, 0, "post_rst_wr");
        do_access(64'h1030, 1'b0, 1'b1, 32'h0, 2, "post_rst_rd");
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        for (int i = 0; i < DEP; i++) mem_model[i] = DW'($urandom);
        test_reset();
        test_write_read();
        test_decode_errors();
        test_random();
        test_back_to_back();
        test_busy_drop();
        test_timeout();
        test_reset_mid_access();
        repeat (2) @(negedge native_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
